// File: rtl/up_bus_arbiter.sv
// Two-master round-robin arbiter for the up register bus, one transaction in flight.
// Optional S_WAIT watchdog enabled by defining UP_ARB_TIMEOUT_EN.
module up_bus_arbiter #(
    parameter int ADDR_WIDTH     = 14,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  up_clk,
    input  logic                  up_rstn,
    input  logic                  m0_wreq,
    input  logic [ADDR_WIDTH-1:0] m0_waddr,
    input  logic [31:0]           m0_wdata,
    output logic                  m0_wack,
    input  logic                  m0_rreq,
    input  logic [ADDR_WIDTH-1:0] m0_raddr,
    output logic [31:0]           m0_rdata,
    output logic                  m0_rack,
    input  logic                  m1_wreq,
    input  logic [ADDR_WIDTH-1:0] m1_waddr,
    input  logic [31:0]           m1_wdata,
    output logic                  m1_wack,
    input  logic                  m1_rreq,
    input  logic [ADDR_WIDTH-1:0] m1_raddr,
    output logic [31:0]           m1_rdata,
    output logic                  m1_rack,
    output logic                  s_wreq,
    output logic [ADDR_WIDTH-1:0] s_waddr,
    output logic [31:0]           s_wdata,
    input  logic                  s_wack,
    output logic                  s_rreq,
    output logic [ADDR_WIDTH-1:0] s_raddr,
    input  logic [31:0]           s_rdata,
    input  logic                  s_rack,
    output logic                  arb_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                state;
    // Slot index is {master, is_read}: 0=M0W, 1=M0R, 2=M1W, 3=M1R.
    logic [3:0]            pend;
    logic [ADDR_WIDTH-1:0] slot_addr [4];
    logic [31:0]           slot_wdata [2];
    logic [1:0]            cur;
    logic                  rr;

    logic [3:0]            req;
    logic [ADDR_WIDTH-1:0] req_addr [4];
    logic [31:0]           req_wdata [2];
    logic [3:0]            clr;
    logic                  first;
    logic [1:0]            pick;
    logic                  ack_now;
    logic                  timed_out;
    logic [31:0]           rdata_val;

`ifdef UP_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
`endif

    always_comb begin
        req          = {m1_rreq, m1_wreq, m0_rreq, m0_wreq};
        req_addr[0]  = m0_waddr;
        req_addr[1]  = m0_raddr;
        req_addr[2]  = m1_waddr;
        req_addr[3]  = m1_raddr;
        req_wdata[0] = m0_wdata;
        req_wdata[1] = m1_wdata;
        clr          = (state == S_DONE) ? (4'b0001 << cur) : '0;

        // Pointer master first if it has anything pending; writes beat reads.
        if (!rr) first = (pend[0] | pend[1]) ? 1'b0 : 1'b1;
        else     first = (pend[2] | pend[3]) ? 1'b1 : 1'b0;
        pick = {first, ~pend[{first, 1'b0}]};

        ack_now = cur[0] ? s_rack : s_wack;
`ifdef UP_ARB_TIMEOUT_EN
        timed_out = !ack_now && (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
        timed_out = 1'b0;
`endif
        rdata_val = timed_out ? 32'hDEAD_DEAD : s_rdata;
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            state    <= S_IDLE;
            pend     <= '0;
            cur      <= '0;
            rr       <= 1'b0;
            s_wreq   <= 1'b0;
            s_rreq   <= 1'b0;
            s_waddr  <= '0;
            s_raddr  <= '0;
            s_wdata  <= '0;
            m0_wack  <= 1'b0;
            m0_rack  <= 1'b0;
            m0_rdata <= '0;
            m1_wack  <= 1'b0;
            m1_rack  <= 1'b0;
            m1_rdata <= '0;
            arb_err  <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) slot_addr[i[1:0]] <= '0;
            slot_wdata[0] <= '0;
            slot_wdata[1] <= '0;
`ifdef UP_ARB_TIMEOUT_EN
            tcnt <= '0;
`endif
        end else begin
            s_wreq   <= 1'b0;
            s_rreq   <= 1'b0;
            m0_wack  <= 1'b0;
            m0_rack  <= 1'b0;
            m0_rdata <= '0;
            m1_wack  <= 1'b0;
            m1_rack  <= 1'b0;
            m1_rdata <= '0;

            // A slot being released this cycle can take a new pulse immediately.
            for (int unsigned i = 0; i < 4; i++) begin
                if (req[i[1:0]]) begin
                    if (pend[i[1:0]] && !clr[i[1:0]]) begin
                        arb_err <= 1'b1;
                    end else begin
                        pend[i[1:0]]      <= 1'b1;
                        slot_addr[i[1:0]] <= req_addr[i[1:0]];
                        if (!i[0]) slot_wdata[i[1]] <= req_wdata[i[1]];
                    end
                end else if (clr[i[1:0]]) begin
                    pend[i[1:0]] <= 1'b0;
                end
            end

            case (state)
                S_IDLE: begin
                    if (|pend) begin
                        cur   <= pick;
                        state <= S_ISSUE;
                        if (pick[0]) begin
                            s_rreq  <= 1'b1;
                            s_raddr <= slot_addr[pick];
                        end else begin
                            s_wreq  <= 1'b1;
                            s_waddr <= slot_addr[pick];
                            s_wdata <= slot_wdata[pick[1]];
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
`ifdef UP_ARB_TIMEOUT_EN
                    tcnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (ack_now || timed_out) begin
                        state   <= S_DONE;
                        s_waddr <= '0;
                        s_raddr <= '0;
                        s_wdata <= '0;
                        if (timed_out) arb_err <= 1'b1;
                        case (cur)
                            2'd0: m0_wack <= 1'b1;
                            2'd1: begin m0_rack <= 1'b1; m0_rdata <= rdata_val; end
                            2'd2: m1_wack <= 1'b1;
                            default: begin m1_rack <= 1'b1; m1_rdata <= rdata_val; end
                        endcase
                    end
`ifdef UP_ARB_TIMEOUT_EN
                    else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= S_IDLE;
                    rr    <= ~cur[1];
                end
            endcase
        end
    end

endmodule

// File: tb/tb_up_bus_arbiter.sv
// Directed-vector bench for up_bus_arbiter with a 1-cycle-ack slave model.
// Timeout scenario is compiled in when UP_ARB_TIMEOUT_EN is defined.
module tb_up_bus_arbiter;
    localparam int AW = 14;

    logic          up_clk = 1'b0;
    logic          up_rstn = 1'b0;
    logic          m0_wreq = 1'b0, m0_rreq = 1'b0, m1_wreq = 1'b0, m1_rreq = 1'b0;
    logic [AW-1:0] m0_waddr = '0, m0_raddr = '0, m1_waddr = '0, m1_raddr = '0;
    logic [31:0]   m0_wdata = '0, m1_wdata = '0;
    logic          m0_wack, m0_rack, m1_wack, m1_rack;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          s_wreq, s_rreq;
    logic [AW-1:0] s_waddr, s_raddr;
    logic [31:0]   s_wdata;
    logic          s_wack = 1'b0, s_rack = 1'b0;
    logic [31:0]   s_rdata = '0;
    logic          arb_err;

    int nerr = 0;
    int nchecks = 0;
    int n_swreq = 0, n_srreq = 0, n_m0rack = 0;
    int base;

    logic        slv_en = 1'b1;
    logic [31:0] slv_data = '0;
    logic        r_d = 1'b0, w_d = 1'b0;

    always #5 up_clk = ~up_clk;

    up_bus_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
        .up_clk(up_clk), .up_rstn(up_rstn),
        .m0_wreq(m0_wreq), .m0_waddr(m0_waddr), .m0_wdata(m0_wdata), .m0_wack(m0_wack),
        .m0_rreq(m0_rreq), .m0_raddr(m0_raddr), .m0_rdata(m0_rdata), .m0_rack(m0_rack),
        .m1_wreq(m1_wreq), .m1_waddr(m1_waddr), .m1_wdata(m1_wdata), .m1_wack(m1_wack),
        .m1_rreq(m1_rreq), .m1_raddr(m1_raddr), .m1_rdata(m1_rdata), .m1_rack(m1_rack),
        .s_wreq(s_wreq), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wack(s_wack),
        .s_rreq(s_rreq), .s_raddr(s_raddr), .s_rdata(s_rdata), .s_rack(s_rack),
        .arb_err(arb_err)
    );

    // Slave answers one cycle after it sees a request pulse.
    always @(posedge up_clk) begin
        #1;
        s_rack  = 1'b0;
        s_wack  = 1'b0;
        s_rdata = '0;
        if (slv_en && r_d) begin
            s_rack  = 1'b1;
            s_rdata = slv_data;
        end
        if (slv_en && w_d) s_wack = 1'b1;
        r_d = s_rreq;
        w_d = s_wreq;
    end

    always @(posedge up_clk) begin
        if (s_wreq)  n_swreq++;
        if (s_rreq)  n_srreq++;
        if (m0_rack) n_m0rack++;
    end

    task automatic tick();
        @(posedge up_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        ticks(2);
        check("rst_s_wreq", 32'(s_wreq), 0);
        check("rst_s_rreq", 32'(s_rreq), 0);
        check("rst_s_addr", 32'({s_waddr, s_raddr}), 0);
        check("rst_s_wdata", s_wdata, 0);
        check("rst_acks", 32'({m0_wack, m0_rack, m1_wack, m1_rack}), 0);
        check("rst_rdata", m0_rdata | m1_rdata, 0);
        check("rst_arb_err", 32'(arb_err), 0);
        up_rstn = 1'b1;
        ticks(2);

        // M0 read 0x0010, slave data 0x1234_5678 (pulse at cycle T)
        slv_data = 32'h1234_5678;
        m0_raddr = 14'h0010; m0_rreq = 1'b1;
        tick();                                   // T+1
        m0_rreq = 1'b0; m0_raddr = '0;
        check("t1_no_early_req", 32'(s_rreq), 0);
        tick();                                   // T+2
        check("t1_s_rreq", 32'(s_rreq), 1);
        check("t1_s_raddr", 32'(s_raddr), 32'h10);
        tick();                                   // T+3
        check("t1_s_rreq_pulse", 32'(s_rreq), 0);
        check("t1_s_raddr_hold", 32'(s_raddr), 32'h10);
        check("t1_rack_early", 32'(m0_rack), 0);
        tick();                                   // T+4
        check("t1_m0_rack", 32'(m0_rack), 1);
        check("t1_m0_rdata", m0_rdata, 32'h1234_5678);
        check("t1_m1_rack", 32'(m1_rack), 0);
        tick();                                   // T+5
        check("t1_rack_pulse", 32'(m0_rack), 0);
        check("t1_rdata_zero", m0_rdata, 0);
        check("t1_s_raddr_idle", 32'(s_raddr), 0);

        // M1 write + read together: write first (rr now points at M1)
        slv_data = 32'h0BAD_F00D;
        m1_wreq = 1'b1; m1_waddr = 14'h0100; m1_wdata = 32'hA5A5_0001;
        m1_rreq = 1'b1; m1_raddr = 14'h0104;
        tick();                                   // T+1
        m1_wreq = 1'b0; m1_rreq = 1'b0; m1_waddr = '0; m1_raddr = '0; m1_wdata = '0;
        tick();                                   // T+2
        check("t3_s_wreq", 32'(s_wreq), 1);
        check("t3_s_rreq_not_yet", 32'(s_rreq), 0);
        check("t3_s_waddr", 32'(s_waddr), 32'h100);
        check("t3_s_wdata", s_wdata, 32'hA5A5_0001);
        ticks(2);                                 // T+4
        check("t3_m1_wack", 32'(m1_wack), 1);
        check("t3_m1_rack_after", 32'(m1_rack), 0);
        ticks(2);                                 // T+6
        check("t3_s_rreq", 32'(s_rreq), 1);
        check("t3_s_raddr", 32'(s_raddr), 32'h104);
        ticks(2);                                 // T+8
        check("t3_m1_rack", 32'(m1_rack), 1);
        check("t3_m1_rdata", m1_rdata, 32'h0BAD_F00D);
        check("t3_m1_wack_once", 32'(m1_wack), 0);
        tick();

        // M0 and M1 writes together with rr = M0
        base = n_swreq;
        m0_wreq = 1'b1; m0_waddr = 14'h0020; m0_wdata = 32'h1111_2222;
        m1_wreq = 1'b1; m1_waddr = 14'h0030; m1_wdata = 32'h3333_4444;
        tick();                                   // T+1
        m0_wreq = 1'b0; m1_wreq = 1'b0;
        tick();                                   // T+2
        check("t2_s_wreq_m0", 32'(s_wreq), 1);
        check("t2_s_waddr_m0", 32'(s_waddr), 32'h20);
        check("t2_s_wdata_m0", s_wdata, 32'h1111_2222);
        ticks(2);                                 // T+4
        check("t2_m0_wack", 32'(m0_wack), 1);
        check("t2_m1_wack_early", 32'(m1_wack), 0);
        ticks(2);                                 // T+6
        check("t2_s_wreq_m1", 32'(s_wreq), 1);
        check("t2_s_waddr_m1", 32'(s_waddr), 32'h30);
        check("t2_s_wdata_m1", s_wdata, 32'h3333_4444);
        ticks(2);                                 // T+8
        check("t2_m1_wack", 32'(m1_wack), 1);
        check("t2_m0_wack_once", 32'(m0_wack), 0);
        tick();
        check("t2_s_wreq_count", 32'(n_swreq - base), 2);

        // Second M0 read while the first is pending is dropped
        check("t4_err_before", 32'(arb_err), 0);
        base = n_m0rack;
        slv_data = 32'h55AA_55AA;
        m0_rreq = 1'b1; m0_raddr = 14'h0040;
        tick();                                   // T+1
        m0_rreq = 1'b0;
        tick();                                   // T+2
        m0_rreq = 1'b1; m0_raddr = 14'h0048;
        tick();                                   // T+3
        m0_rreq = 1'b0; m0_raddr = '0;
        check("t4_arb_err", 32'(arb_err), 1);
        check("t4_s_raddr_first", 32'(s_raddr), 32'h40);
        tick();                                   // T+4
        check("t4_m0_rack", 32'(m0_rack), 1);
        check("t4_m0_rdata", m0_rdata, 32'h55AA_55AA);
        ticks(8);
        check("t4_one_rack", 32'(n_m0rack - base), 1);
        check("t4_err_sticky", 32'(arb_err), 1);

        // Reset during S_WAIT aborts the transaction
        slv_en = 1'b0;
        m0_rreq = 1'b1; m0_raddr = 14'h0050;
        tick();
        m0_rreq = 1'b0; m0_raddr = '0;
        ticks(2);                                 // T+3, in S_WAIT
        check("t5_s_raddr_wait", 32'(s_raddr), 32'h50);
        base = n_m0rack;
        #2 up_rstn = 1'b0;
        #1;
        check("t5_rst_s_raddr", 32'(s_raddr), 0);
        check("t5_rst_arb_err", 32'(arb_err), 0);
        check("t5_rst_acks", 32'({m0_wack, m0_rack, m1_wack, m1_rack, s_wreq, s_rreq}), 0);
        ticks(2);
        up_rstn = 1'b1;
        slv_en = 1'b1;
        ticks(3);
        check("t5_no_ack", 32'(n_m0rack - base), 0);
        slv_data = 32'hCAFE_BABE;
        m0_rreq = 1'b1; m0_raddr = 14'h0060;
        tick();
        m0_rreq = 1'b0; m0_raddr = '0;
        tick();                                   // T+2
        check("t5_s_rreq", 32'(s_rreq), 1);
        check("t5_s_raddr", 32'(s_raddr), 32'h60);
        ticks(2);                                 // T+4
        check("t5_m0_rack", 32'(m0_rack), 1);
        check("t5_m0_rdata", m0_rdata, 32'hCAFE_BABE);
        tick();

`ifdef UP_ARB_TIMEOUT_EN
        // Slave never acks: forced completion after 8 cycles in S_WAIT
        check("t6_err_before", 32'(arb_err), 0);
        slv_en = 1'b0;
        m0_rreq = 1'b1; m0_raddr = 14'h0070;
        tick();
        m0_rreq = 1'b0; m0_raddr = '0;
        ticks(9);                                 // T+10, last S_WAIT cycle
        check("t6_no_early_rack", 32'(m0_rack), 0);
        tick();                                   // T+11
        check("t6_m0_rack", 32'(m0_rack), 1);
        check("t6_m0_rdata", m0_rdata, 32'hDEAD_DEAD);
        check("t6_arb_err", 32'(arb_err), 1);
        tick();
        check("t6_rack_pulse", 32'(m0_rack), 0);
        slv_en = 1'b1;
        ticks(2);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end
endmodule
